// File: rtl/nibble_serial_add_ctrl.sv
// Serial WIDTH-bit adder: one shared 4-bit ripple slice, one nibble per clock, LSB nibble first.
// Optional subtract support is enabled by defining NIBBLE_ADD_SUB_EN.

module nibble_add_slice (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c3_o,
  output logic       co_o
);

  logic [4:0] c;

  always_comb begin
    c    = '0;
    s_o  = '0;
    c[0] = c_i;
    for (int unsigned i = 0; i < 4; i++) begin
      s_o[i]  = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]  = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign c3_o = c[3];
  assign co_o = c[4];

endmodule

module nibble_serial_add_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
`ifdef NIBBLE_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N  = WIDTH / 4;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [3:0] nib_a, nib_b, nib_s;
  logic       nib_c3, nib_co;

  // Operand nibble select for the current step.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (idx_q == IW'(i)) begin
        nib_a = a_q[4*i +: 4];
        nib_b = b_q[4*i +: 4];
      end
    end
  end

  nibble_add_slice u_slice (
    .a_i  (nib_a),
    .b_i  (nib_b),
    .c_i  (carry_q),
    .s_o  (nib_s),
    .c3_o (nib_c3),
    .co_o (nib_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          a_d     = op_a;
`ifdef NIBBLE_ADD_SUB_EN
          // Subtract as A + ~B + 1; cin is ignored in that mode.
          b_d     = sub ? ~op_b : op_b;
          carry_d = sub ? 1'b1 : cin;
`else
          b_d     = op_b;
          carry_d = cin;
`endif
          idx_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        for (int unsigned i = 0; i < N; i++) begin
          if (idx_q == IW'(i)) begin
            sum_d[4*i +: 4] = nib_s;
          end
        end
        carry_d = nib_co;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST) begin
          cout_d  = nib_co;
          ovf_d   = nib_c3 ^ nib_co;
          state_d = DONE;
        end
      end

      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign res_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
